// File: rtl/lsu_wb_bridge_pkg.sv
// Shared definitions for the load/store unit Wishbone bridge.
// Contents: funct3 access encodings, FSM state encoding, byte-select width,
// and a helper that maps funct3 onto an access size.
package lsu_wb_bridge_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Undefined encodings (011, 110, 111) fall through to a word access.
  function automatic size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = SZ_BYTE;
      F3_H, F3_HU: access_size = SZ_HALF;
      default:     access_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the LSU bridge.
// Ports:
//   funct3     access size/sign
//   addr_lo    byte offset within the word
//   wdata      right-justified store data
//   bus_rdata  raw Wishbone read word
//   wb_dat     lane-replicated store data
//   wb_sel     byte selects
//   load_data  extracted and sign/zero-extended load value
//   misaligned access does not fit its natural alignment
module lsu_lane_align
  import lsu_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] wb_dat,
  output logic [WB_SEL_W-1:0]   wb_sel,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_unsigned;

  always_comb begin
    // One right shift by the byte offset serves both byte and half loads;
    // for an aligned half the offset is 0 or 2.
    shifted     = bus_rdata >> {addr_lo, 3'b000};
    is_unsigned = funct3[2];
    wb_dat      = wdata;
    wb_sel      = 4'b1111;
    load_data   = bus_rdata;
    misaligned  = 1'b0;
    case (access_size(funct3))
      SZ_BYTE: begin
        wb_dat    = {4{wdata[7:0]}};
        wb_sel    = 4'b0001 << addr_lo;
        load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        wb_dat     = {2{wdata[15:0]}};
        wb_sel     = 4'b0011 << {addr_lo[1], 1'b0};
        load_data  = is_unsigned ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/lsu_wb_bridge.sv
// Load/store unit: turns each MEM-stage access into one Wishbone classic
// cycle, stalls the pipeline while it is outstanding, and returns extended
// load data with a one-cycle o_done pulse.
// Optional build macro LSU_TIMEOUT_EN adds a bus wait limit of
// TIMEOUT_CYCLES BUS cycles, ending the access with o_bus_err.
// Ports:
//   clk, rst (async active-low)
//   i_req_M/i_we_M/i_funct3_M/i_addr_M/i_wdata_M  MEM-stage request
//   o_rdata_M/o_done/o_stall/o_misaligned/o_bus_err  pipeline response
//   o_wb_* / i_wb_*  Wishbone classic master
//   dbg_state  current FSM state
// Handshake: the MEM request is sampled only in IDLE; the pipeline holds it
// while o_stall=1 and advances in the cycle where o_done=1. On the bus,
// cyc/stb stay high until a cycle in which ack or err is seen (err wins).
module lsu_wb_bridge
  import lsu_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_M,
  input  logic                  i_we_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_wdata_M,
  output logic [DATA_WIDTH-1:0] o_rdata_M,
  output logic                  o_done,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [DATA_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0]   o_wb_sel,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  output logic [1:0]            dbg_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t                state_q, state_d;
  logic                  we_q, mis_q, err_q;
  logic [2:0]            f3_q;
  logic [1:0]            lo_q;
  logic [DATA_WIDTH-1:0] adr_q, dat_q, rdata_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic                  expire;

  logic [2:0]            al_f3;
  logic [1:0]            al_lo;
  logic [DATA_WIDTH-1:0] al_dat, al_load;
  logic [WB_SEL_W-1:0]   al_sel;
  logic                  al_mis;

  // In IDLE the aligner looks at the incoming request; in BUS it looks at
  // the latched request so the load extract matches the issued access.
  assign al_f3 = (state_q == ST_IDLE) ? i_funct3_M    : f3_q;
  assign al_lo = (state_q == ST_IDLE) ? i_addr_M[1:0] : lo_q;

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .wdata      (i_wdata_M),
    .bus_rdata  (i_wb_dat),
    .wb_dat     (al_dat),
    .wb_sel     (al_sel),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q;
  // The counter holds the number of silent BUS cycles already elapsed, so
  // comparing against TIMEOUT_CYCLES-1 ends the access after exactly
  // TIMEOUT_CYCLES BUS cycles. Ack/err are checked first and win.
  assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_stall = i_req_M;
        if (i_req_M) state_d = al_mis ? ST_DONE : ST_BUS;
      end
      ST_BUS: begin
        o_stall = 1'b1;
        if (i_wb_err || i_wb_ack || expire) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      lo_q    <= 2'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (i_req_M) begin
            mis_q   <= al_mis;
            err_q   <= 1'b0;
            rdata_q <= '0;
            if (!al_mis) begin
              we_q  <= i_we_M;
              f3_q  <= i_funct3_M;
              lo_q  <= i_addr_M[1:0];
              adr_q <= {i_addr_M[DATA_WIDTH-1:2], 2'b00};
              dat_q <= al_dat;
              sel_q <= al_sel;
            end
          end
        end
        ST_BUS: begin
          if (i_wb_err) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (i_wb_ack) begin
            rdata_q <= we_q ? '0 : al_load;
          end else if (expire) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    cnt_q <= 8'd0;
    else if (state_q != ST_BUS)                  cnt_q <= 8'd0;
    else if (!i_wb_ack && !i_wb_err && !expire)  cnt_q <= cnt_q + 8'd1;
  end
`endif

  assign o_wb_cyc     = (state_q == ST_BUS);
  assign o_wb_stb     = (state_q == ST_BUS);
  assign o_wb_we      = we_q;
  assign o_wb_adr     = adr_q;
  assign o_wb_dat     = dat_q;
  assign o_wb_sel     = sel_q;
  assign o_done       = (state_q == ST_DONE);
  assign o_misaligned = (state_q == ST_DONE) && mis_q;
  assign o_bus_err    = (state_q == ST_DONE) && err_q;
  assign o_rdata_M    = (state_q == ST_DONE) ? rdata_q : '0;
  assign dbg_state    = state_q;

endmodule

// File: doc/lsu_wb_bridge.md
Name: lsu_wb_bridge

Overview:
- Load/store unit sitting directly downstream of the datapath MEM stage.
- Consumes the datapath's data address, store data and write-enable, and turns each access into a single Wishbone classic master cycle toward the Caravel-side data memory.
- Stalls the pipeline while the bus cycle is outstanding.
- Returns byte/half/word load data, extended to 32 bits, to the datapath read-data input.

Parameters:
- DATA_WIDTH, 32, data and address width (only 32 supported).
- TIMEOUT_CYCLES, 255, bus wait limit in cycles; used only when LSU_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_req_M  in  1  MEM stage holds a load or store.
- i_we_M  in  1  1 = store, 0 = load.
- i_funct3_M  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- i_addr_M  in  DATA_WIDTH  byte address.
- i_wdata_M  in  DATA_WIDTH  store data, right-justified.
- o_rdata_M  out  DATA_WIDTH  extended load data; valid while o_done=1.
- o_done  out  1  one-cycle pulse when the access completes.
- o_stall  out  1  freeze IF/ID/EX/MEM.
- o_misaligned  out  1  one-cycle pulse with o_done; access not issued.
- o_bus_err  out  1  one-cycle pulse with o_done; bus error or timeout.
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle/strobe.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_adr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}.
- o_wb_dat  out  DATA_WIDTH  lane-replicated store data.
- o_wb_sel  out  4  byte selects.
- i_wb_dat  in  DATA_WIDTH  read data.
- i_wb_ack  in  1  acknowledge.
- i_wb_err  in  1  error.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including o_rdata_M. cyc/stb drop immediately, even mid-cycle. No completion pulse follows.
- States: IDLE, BUS, DONE.
- IDLE:
  - o_stall = i_req_M (combinational).
  - If i_req_M and aligned: latch adr/dat/sel/we; next state BUS.
  - If i_req_M and misaligned: next state DONE with misaligned flag; no bus cycle.
- Misaligned definition: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- BUS:
  - cyc=stb=1 (registered); o_stall=1.
  - i_wb_ack: capture extended load data; next state DONE.
  - i_wb_err: rdata=0, err flag; next state DONE.
  - ack and err together: err wins.
- DONE:
  - o_done=1, o_stall=0, cyc=stb=0; exactly one cycle; next state IDLE.
  - The new MEM instruction is sampled in the following IDLE cycle, so back-to-back accesses never overlap.
- Latency: request to o_done = 2 + ack wait cycles (ack on first BUS cycle gives o_done 2 cycles after the request cycle).
- Misaligned access: o_done 1 cycle after request.
- Store lanes:
  - SB: dat = {4{b}}, sel = 0001 << addr[1:0].
  - SH: dat = {2{h}}, sel = 0011 << {addr[1],1'b0}.
  - SW: sel = 1111.
- Load extract: select byte/half by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Stores complete with o_rdata_M = 0.
- Undefined funct3 (011, 110, 111): treated as LW/SW.
- i_req_M changes during BUS are ignored; the latched request completes.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - 8-bit wait counter, cleared on BUS entry, increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, go to DONE with o_bus_err=1, rdata=0.
  - Ack in the same cycle as expiry wins.
- LSU_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack/err.

Decomposition:
- Shared package holds:
  - funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state encodings (ST_IDLE, ST_BUS, ST_DONE).
  - WB_SEL_W = 4.
- One combinational sub-module, lsu_lane_align: store dat/sel generation, load extract/extend, misaligned detect.
- The FSM, registers and timeout live in lsu_wb_bridge.

Test Plan:
1. SW addr=0x0000_1004, wdata=0xDEADBEEF, ack after 3 cycles -> adr=0x1004, sel=1111, we=1, o_stall high 4 cycles, o_done one pulse, rdata=0.
2. LB addr=0x1003, wb_dat=0x80FF_1234 -> o_rdata_M=0xFFFF_FF80; repeat LBU -> 0x0000_0080; LH addr=0x1002 -> 0xFFFF_80FF.
3. SB addr=0x2001, wdata=0x0000_00AB -> o_wb_dat=0xABABABAB, sel=0010; SH addr=0x2002 -> sel=1100.
4. LW addr=0x1002 -> no cyc asserted, o_misaligned and o_done pulse 1 cycle after request, stall 1 cycle.
5. LW, i_wb_err in BUS -> o_bus_err=1, rdata=0. Separately, rst driven low while cyc=1 -> cyc/stb=0 same cycle, no o_done after release.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never -> cyc drops after 4 BUS cycles, o_bus_err pulse. Undefined macro -> stall holds for 20+ cycles.
